fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch initiator for the femtoRV32 core. It drives the instruction side of the shared single-ported byte-addressed memory, which returns a little-endian 32-bit word plus a regular/compressed flag. It uses that flag to advance the PC by 4 or 2, and buffers fetched instructions in a small FIFO with a valid/ready handshake toward decode. Branch and jump redirects flush the buffer, and any in-flight stale response is discarded.

## Interface
- `RESET_PC`, default 32'h0: fetch address after reset; bit 0 is ignored.
- `DEPTH`, default 2: instruction buffer entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `mem_req` out 1: instruction-fetch request to memory; also the instruction-phase select.
- `mem_addr` out 32: byte address of the fetch; always even.
- `mem_rdata` in 32: word `{m[a+3],m[a+2],m[a+1],m[a]}`.
- `mem_is_regular` in 1: 1 when `m[a][1:0]==2'b11`, i.e. a 32-bit instruction.
- `mem_valid` in 1: response strobe; `mem_rdata` and `mem_is_regular` are valid in that cycle.
- `redirect` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch PC; bit 0 is forced to 0.
- `inst_valid` out 1: buffer head valid.
- `inst_ready` in 1: decode accepts the head.
- `inst` out 32: head instruction; compressed instructions are zero-extended `{16'b0, rdata[15:0]}`.
- `inst_pc` out 32: PC of the head instruction.
- `inst_is_compressed` out 1: head is a 16-bit instruction.

## Operation
- Registers:
  - `fetch_pc`.
  - FIFO of `{inst, pc, compressed}` with `DEPTH` entries and `count` in `0..DEPTH`.
  - FSM `state` ∈ {FETCH, HOLD, DRAIN}.
  - At most one request is outstanding.
- FETCH:
  - `mem_req=1` and `mem_addr=fetch_pc`, held stable until `mem_valid`.
  - On `mem_valid`: push the entry and advance `fetch_pc += mem_is_regular ? 4 : 2` (32-bit wrap).
  - After the push, if `count_next < DEPTH`, stay in FETCH and present the next address in the following cycle. Otherwise go to HOLD.
- HOLD:
  - `mem_req=0`.
  - Return to FETCH in the cycle after a pop makes `count < DEPTH`.
- DRAIN:
  - Entered when a redirect arrives while a request is outstanding without `mem_valid` in the same cycle.
  - `mem_req=0`.
  - Wait for `mem_valid`, discard the response (no push, no PC update), then go to FETCH.
- Pop: occurs when `inst_valid && inst_ready`; the head advances.
- Simultaneous push and pop: `count` is unchanged.
- Push when full: cannot occur by construction. The bench asserts against it.
- Redirect has priority over push, pop and advance in the same cycle:
  - FIFO is flushed and `count=0`.
  - `fetch_pc <= {redirect_pc[31:1],1'b0}`.
  - Next state is DRAIN if a request is outstanding without `mem_valid` this cycle, else FETCH.
  - A `mem_valid` arriving in the redirect cycle is discarded.
- `inst_valid = (count != 0)`.
  - Head outputs are held stable while `inst_valid && !inst_ready`.
  - Head outputs are 0 when empty.

## Timing
- Reset values:
  - `mem_req=0`, `mem_addr=RESET_PC & ~1`, `state=FETCH`, `count=0`.
  - `inst_valid=0`, `inst=0`, `inst_pc=0`, `inst_is_compressed=0`.
- All outputs are registered or derived directly from registers. There are no combinational input-to-output paths.
- `mem_req` rises on the first rising edge after `rst` deasserts.
- Memory latency is ≥1 cycle after `mem_req` is sampled.
- `inst_valid` rises on the edge after the `mem_valid` cycle, so fetch-to-decode latency is one cycle after the response.
- With 1-cycle memory latency and decode always ready, throughput is one instruction per 2 cycles.
- After a redirect, the first new request is issued:
  - on the next edge if nothing was outstanding;
  - otherwise on the edge after the stale `mem_valid`.
- Reset mid-operation:
  - All state clears immediately, asynchronously.
  - A `mem_valid` arriving after `rst` deasserts but before the first new request is ignored.

## Test plan
- Reset release with `RESET_PC=32'h10`: `mem_req` goes 0→1 one cycle after release with `mem_addr=0x10`. All `inst*` outputs stay 0 until the first response.
- Mixed stream: memory returns regular, compressed, compressed, regular at 1-cycle latency. Decode sees `inst_pc` 0, 4, 6, 8 with `inst_is_compressed` 0, 1, 1, 0, and compressed `inst` upper 16 bits are 0.
- Backpressure, `inst_ready=0`: after 2 pushes `mem_req=0` (HOLD) and the head stays stable. Raising `inst_ready` for one cycle restarts fetch at the next sequential PC.
- Redirect to `0x41` while a request is outstanding: FSM goes to DRAIN and the stale response is not pushed. The next `mem_addr=0x40`, and the FIFO is empty on the cycle after the redirect.
- Redirect, pop and `mem_valid` in the same cycle: `count=0`, nothing is pushed, and `fetch_pc=redirect_pc`.
- `rst` asserted mid-stream with 2 entries buffered: outputs clear asynchronously. After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_if.sv
// Instruction-side memory port and decode handshake for fetch_unit.
// master = fetch unit, slave = memory/decode environment.
interface fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_is_regular;
    logic        mem_valid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_compressed;

    modport master (
        output mem_req, mem_addr,
        input  mem_rdata, mem_is_regular, mem_valid,
        input  redirect, redirect_pc,
        output inst_valid, inst, inst_pc, inst_is_compressed,
        input  inst_ready
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_rdata, mem_is_regular, mem_valid,
        output redirect, redirect_pc,
        input  inst_valid, inst, inst_pc, inst_is_compressed,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// femtoRV32 instruction fetch: one outstanding request, PC += 4/2 by response
// width, small instruction FIFO toward decode, redirect flush with stale-drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned DEPTH    = 2
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

    state_e          state_q;
    logic            mem_req_q;
    logic [31:0]     fetch_pc_q;
    logic [CntW-1:0] count_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic        comp_mem [DEPTH];

    logic            outstanding;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [CntW-1:0] count_next;
    logic [31:0]     pc_next;

    // mem_req_q is only ever high in StFetch, so it doubles as "request issued".
    always_comb begin
        outstanding = mem_req_q || (state_q == StDrain);
        push        = mem_req_q && bus.mem_valid && !bus.redirect;
        head_valid  = (count_q != '0);
        pop         = head_valid && bus.inst_ready && !bus.redirect;
        count_next  = count_q + CntW'(push) - CntW'(pop);
        pc_next     = fetch_pc_q + (bus.mem_is_regular ? 32'd4 : 32'd2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFetch;
            mem_req_q  <= 1'b0;
            fetch_pc_q <= {RESET_PC[31:1], 1'b0};
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else if (bus.redirect) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fetch_pc_q <= {bus.redirect_pc[31:1], 1'b0};
            if (outstanding && !bus.mem_valid) begin
                state_q   <= StDrain;
                mem_req_q <= 1'b0;
            end else begin
                state_q   <= StFetch;
                mem_req_q <= 1'b1;
            end
        end else begin
            count_q <= count_next;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case (state_q)
                StFetch: begin
                    if (push) fetch_pc_q <= pc_next;
                    if (push && count_next == Full) begin
                        state_q   <= StHold;
                        mem_req_q <= 1'b0;
                    end else begin
                        mem_req_q <= 1'b1;
                    end
                end
                StHold: begin
                    if (pop) begin
                        state_q   <= StFetch;
                        mem_req_q <= 1'b1;
                    end
                end
                StDrain: begin
                    // Stale response is swallowed; refetch from the redirect PC.
                    if (bus.mem_valid) begin
                        state_q   <= StFetch;
                        mem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StFetch;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= bus.mem_is_regular ? bus.mem_rdata
                                                     : {16'b0, bus.mem_rdata[15:0]};
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            comp_mem[wr_ptr_q] <= !bus.mem_is_regular;
        end
    end

    assign bus.mem_req            = mem_req_q;
    assign bus.mem_addr           = fetch_pc_q;
    assign bus.inst_valid         = head_valid;
    assign bus.inst               = head_valid ? inst_mem[rd_ptr_q] : 32'b0;
    assign bus.inst_pc            = head_valid ? pc_mem[rd_ptr_q] : 32'b0;
    assign bus.inst_is_compressed = head_valid && comp_mem[rd_ptr_q];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, redirect/drain, mixed stream,
// backpressure, redirect+pop+valid collision and mid-stream reset.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic clk;
    logic rst;
    fetch_if bus ();

    fetch_unit #(
        .RESET_PC (32'h11),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int full_push_seen = 0;
    logic auto_mem = 1'b0;
    logic [7:0] mem [0:255];

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        logic        exp_c;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [16];

    always @(posedge clk) begin
        if (!rst && int'(dut.count_q) == DEPTH && dut.push) full_push_seen++;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] i;
        i = a[7:0];
        return {mem[i + 8'd3], mem[i + 8'd2], mem[i + 8'd1], mem[i]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic v, input logic [31:0] i,
                              input logic [31:0] p, input logic c);
        check({tag, " inst_valid"}, 32'(bus.inst_valid), 32'(v));
        check({tag, " inst"}, bus.inst, i);
        check({tag, " inst_pc"}, bus.inst_pc, p);
        check({tag, " inst_is_compressed"}, 32'(bus.inst_is_compressed), 32'(c));
    endtask

    task automatic check_mem(input string tag, input logic r, input logic [31:0] a);
        check({tag, " mem_req"}, 32'(bus.mem_req), 32'(r));
        check({tag, " mem_addr"}, bus.mem_addr, a);
    endtask

    // One clock; memory answers one cycle after sampling mem_req, one beat per request.
    task automatic step();
        logic        req_s;
        logic [31:0] addr_s;
        req_s  = bus.mem_req;
        addr_s = bus.mem_addr;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            if (bus.mem_valid) begin
                bus.mem_valid = 1'b0;
            end else if (req_s) begin
                bus.mem_valid      = 1'b1;
                bus.mem_rdata      = word_at(addr_s);
                bus.mem_is_regular = (mem[addr_s[7:0]][1:0] == 2'b11);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit done;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            if (i >= 12 && (i % 4) == 0) mem[i] = 8'h13;
            if (i >= 12 && (i % 4) == 3) mem[i] = 8'(i - 3);
        end
        {mem[3], mem[2], mem[1], mem[0]}   = 32'h00A0_0093;
        {mem[7], mem[6], mem[5], mem[4]}   = 32'h0001_4505;
        {mem[11], mem[10], mem[9], mem[8]} = 32'h0020_8133;

        //             ready v  inst          pc      c  req addr
        vecs[0]  = '{1'b1, 0, 32'h0,          32'h00, 0, 1, 32'h00};
        vecs[1]  = '{1'b1, 1, 32'h00A0_0093,  32'h00, 0, 1, 32'h04};
        vecs[2]  = '{1'b1, 0, 32'h0,          32'h00, 0, 1, 32'h04};
        vecs[3]  = '{1'b1, 1, 32'h0000_4505,  32'h04, 1, 1, 32'h06};
        vecs[4]  = '{1'b1, 0, 32'h0,          32'h00, 0, 1, 32'h06};
        vecs[5]  = '{1'b1, 1, 32'h0000_0001,  32'h06, 1, 1, 32'h08};
        vecs[6]  = '{1'b1, 0, 32'h0,          32'h00, 0, 1, 32'h08};
        vecs[7]  = '{1'b1, 1, 32'h0020_8133,  32'h08, 0, 1, 32'h0C};
        vecs[8]  = '{1'b1, 0, 32'h0,          32'h00, 0, 1, 32'h0C};
        vecs[9]  = '{1'b0, 1, 32'h0C00_0013,  32'h0C, 0, 1, 32'h10};
        vecs[10] = '{1'b0, 1, 32'h0C00_0013,  32'h0C, 0, 1, 32'h10};
        vecs[11] = '{1'b0, 1, 32'h0C00_0013,  32'h0C, 0, 0, 32'h14};
        vecs[12] = '{1'b0, 1, 32'h0C00_0013,  32'h0C, 0, 0, 32'h14};
        vecs[13] = '{1'b1, 1, 32'h1000_0013,  32'h10, 0, 1, 32'h14};
        vecs[14] = '{1'b0, 1, 32'h1000_0013,  32'h10, 0, 1, 32'h14};
        vecs[15] = '{1'b0, 1, 32'h1000_0013,  32'h10, 0, 0, 32'h18};

        rst                = 1'b1;
        bus.mem_rdata      = 32'h0;
        bus.mem_is_regular = 1'b0;
        bus.mem_valid      = 1'b0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;

        // Reset state; bit 0 of RESET_PC dropped
        repeat (3) @(posedge clk);
        #1;
        check_mem("reset", 1'b0, 32'h10);
        check_head("reset", 1'b0, 32'h0, 32'h0, 1'b0);

        // Release with a spurious response present: must be ignored
        rst                = 1'b0;
        bus.mem_valid      = 1'b1;
        bus.mem_rdata      = 32'hDEAD_BEEF;
        bus.mem_is_regular = 1'b1;
        #1;
        check_mem("post_release", 1'b0, 32'h10);
        step();
        check_mem("first_req", 1'b1, 32'h10);
        check_head("first_req", 1'b0, 32'h0, 32'h0, 1'b0);
        bus.mem_valid = 1'b0;
        step();
        check_mem("req_held", 1'b1, 32'h10);
        check_head("spurious_ignored", 1'b0, 32'h0, 32'h0, 1'b0);

        // Redirect while outstanding -> drain the stale response
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h41;
        step();
        bus.redirect = 1'b0;
        check_mem("drain_enter", 1'b0, 32'h40);
        check_head("drain_enter", 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        check_mem("drain_wait", 1'b0, 32'h40);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 32'h1234_5673;
        step();
        bus.mem_valid = 1'b0;
        check_mem("drain_exit", 1'b1, 32'h40);
        check_head("drain_exit", 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        check_head("stale_not_pushed", 1'b0, 32'h0, 32'h0, 1'b0);

        // Redirect coinciding with a response: response discarded, no drain
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        bus.mem_valid   = 1'b1;
        step();
        bus.redirect  = 1'b0;
        bus.mem_valid = 1'b0;
        check_mem("redir_valid", 1'b1, 32'h0);
        check_head("redir_valid", 1'b0, 32'h0, 32'h0, 1'b0);

        // Mixed stream, then backpressure, from the vector table
        auto_mem = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.inst_ready = vecs[k].ready;
            step();
            check_head($sformatf("vec%0d", k), vecs[k].exp_valid, vecs[k].exp_inst,
                       vecs[k].exp_pc, vecs[k].exp_c);
            check_mem($sformatf("vec%0d", k), vecs[k].exp_req, vecs[k].exp_addr);
        end

        // Redirect + pop + mem_valid in one cycle with a non-empty FIFO
        auto_mem       = 1'b0;
        bus.inst_ready = 1'b1;
        step();
        check_mem("pop_from_hold", 1'b1, 32'h18);
        check_head("pop_from_hold", 1'b1, 32'h1400_0013, 32'h14, 1'b0);
        bus.inst_ready = 1'b0;
        step();
        bus.inst_ready     = 1'b1;
        bus.redirect       = 1'b1;
        bus.redirect_pc    = 32'h81;
        bus.mem_valid      = 1'b1;
        bus.mem_rdata      = word_at(32'h18);
        bus.mem_is_regular = 1'b1;
        step();
        bus.redirect   = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.inst_ready = 1'b0;
        check_mem("collide", 1'b1, 32'h80);
        check_head("collide", 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        check_head("collide_no_push", 1'b0, 32'h0, 32'h0, 1'b0);

        // Fill to HOLD, then reset mid-stream
        auto_mem = 1'b1;
        done     = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            step();
            if (!bus.mem_req) done = 1'b1;
        end
        check("fill_reached_hold", 32'(done), 32'd1);
        check_head("filled", 1'b1, 32'h8000_0013, 32'h80, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_mem("async_reset", 1'b0, 32'h10);
        check_head("async_reset", 1'b0, 32'h0, 32'h0, 1'b0);
        auto_mem      = 1'b0;
        bus.mem_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check_mem("restart", 1'b1, 32'h10);
        check_head("restart", 1'b0, 32'h0, 32'h0, 1'b0);

        check("push_when_full", 32'(full_push_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
